// File: rtl/x_23k640_req_queue.sv
// Request/completion queue in front of the 23K640 SPI data engine.
// Read dispatch waits for completion-buffer credit, because the engine cannot stall.
module x_23k640_req_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_rd_n_wr,
  input  logic [15:0]      i_req_addr,
  input  logic [7:0]       i_req_wdata,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_cpl_valid,
  input  logic             i_cpl_ready,
  output logic [TAG_W-1:0] o_cpl_tag,
  output logic [7:0]       o_cpl_rdata,
  output logic             o_valid,
  input  logic             i_accept,
  output logic             o_rd_n_wr,
  output logic [15:0]      o_addr,
  output logic [7:0]       o_wdata,
  input  logic             i_ready,
  input  logic [7:0]       i_rdata,
  output logic             o_idle,
  output logic             o_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = PW + 1;

  typedef struct packed {
    logic             rd_n_wr;
    logic [15:0]      addr;
    logic [7:0]       wdata;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [7:0]       rdata;
  } cpl_t;

  req_t             req_mem_q [DEPTH];
  cpl_t             cpl_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [2];

  logic [PW-1:0] req_wp_q, req_wp_d, req_rp_q, req_rp_d;
  logic [PW-1:0] cpl_wp_q, cpl_wp_d, cpl_rp_q, cpl_rp_d;
  logic          tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [1:0]    infl_q, infl_d;
  logic          err_q, err_d;

  logic [PW-1:0] req_cnt, cpl_cnt;
  logic          req_full, req_empty, cpl_full, cpl_empty;
  logic          credit_ok;
  logic          req_push, req_pop, rd_acc, tag_push, rdy_ok, cpl_push, cpl_pop;
  req_t          req_in, head;
  cpl_t          cpl_in, cpl_head;

  assign req_cnt   = req_wp_q - req_rp_q;
  assign cpl_cnt   = cpl_wp_q - cpl_rp_q;
  assign req_full  = (req_cnt == PW'(DEPTH));
  assign req_empty = (req_cnt == '0);
  assign cpl_full  = (cpl_cnt == PW'(DEPTH));
  assign cpl_empty = (cpl_cnt == '0);
  assign head      = req_mem_q[req_rp_q[AW-1:0]];
  assign cpl_head  = cpl_mem_q[cpl_rp_q[AW-1:0]];

  // A read may only go out if its completion is guaranteed a slot.
  assign credit_ok = (SW'(cpl_cnt) + SW'(infl_q)) < SW'(DEPTH);

  assign req_push = i_req_valid & ~req_full;
  assign req_pop  = i_accept & ~req_empty;
  assign rd_acc   = req_pop & head.rd_n_wr;
  assign tag_push = rd_acc & (infl_q != 2'd2);
  assign rdy_ok   = i_ready & (infl_q != 2'd0);
  assign cpl_pop  = i_cpl_ready & ~cpl_empty;
  assign cpl_push = rdy_ok & (~cpl_full | cpl_pop);

  assign req_in = '{i_req_rd_n_wr, i_req_addr, i_req_wdata, i_req_tag};
  assign cpl_in = '{tag_mem_q[tag_rp_q], i_rdata};

  // Next-state for pointers, in-flight count and sticky error.
  always_comb begin
    req_wp_d = req_wp_q;
    req_rp_d = req_rp_q;
    cpl_wp_d = cpl_wp_q;
    cpl_rp_d = cpl_rp_q;
    tag_wp_d = tag_wp_q;
    tag_rp_d = tag_rp_q;
    infl_d   = infl_q;
    err_d    = err_q;
    if (req_push) req_wp_d = req_wp_q + PW'(1);
    if (req_pop)  req_rp_d = req_rp_q + PW'(1);
    if (cpl_push) cpl_wp_d = cpl_wp_q + PW'(1);
    if (cpl_pop)  cpl_rp_d = cpl_rp_q + PW'(1);
    if (tag_push) tag_wp_d = ~tag_wp_q;
    if (rdy_ok)   tag_rp_d = ~tag_rp_q;
    case ({tag_push, rdy_ok})
      2'b10:   infl_d = infl_q + 2'd1;
      2'b01:   infl_d = infl_q - 2'd1;
      default: infl_d = infl_q;
    endcase
    if ((i_accept & req_empty) | (i_ready & (infl_q == 2'd0)) | (rd_acc & (infl_q == 2'd2)))
      err_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_wp_q <= '0;
      req_rp_q <= '0;
      cpl_wp_q <= '0;
      cpl_rp_q <= '0;
      tag_wp_q <= 1'b0;
      tag_rp_q <= 1'b0;
      infl_q   <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      req_wp_q <= req_wp_d;
      req_rp_q <= req_rp_d;
      cpl_wp_q <= cpl_wp_d;
      cpl_rp_q <= cpl_rp_d;
      tag_wp_q <= tag_wp_d;
      tag_rp_q <= tag_rp_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (req_push) req_mem_q[req_wp_q[AW-1:0]] <= req_in;
    if (cpl_push) cpl_mem_q[cpl_wp_q[AW-1:0]] <= cpl_in;
    if (tag_push) tag_mem_q[tag_wp_q] <= head.tag;
  end

  assign o_req_ready = ~req_full;
  assign o_valid     = ~req_empty & (~head.rd_n_wr | credit_ok);
  assign o_rd_n_wr   = head.rd_n_wr;
  assign o_addr      = head.addr;
  assign o_wdata     = head.wdata;
  assign o_cpl_valid = ~cpl_empty;
  assign o_cpl_tag   = cpl_head.tag;
  assign o_cpl_rdata = cpl_head.rdata;
  assign o_idle      = req_empty & (infl_q == 2'd0) & cpl_empty;
  assign o_err       = err_q;

endmodule

// File: tb/tb_x_23k640_req_queue.sv
// Bench for x_23k640_req_queue: directed scenarios plus randomized traffic
// checked against a queue-based model of the request/credit/completion rules.
module tb_x_23k640_req_queue;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_rd = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [3:0] req_tag = '0;
  logic cpl_ready = 1'b0, accept = 1'b0, ready = 1'b0;
  logic [7:0] rdata = '0;

  logic o_req_ready, o_cpl_valid, o_valid, o_rd_n_wr, o_idle, o_err;
  logic [3:0] o_cpl_tag;
  logic [7:0] o_cpl_rdata, o_wdata;
  logic [15:0] o_addr;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { bit rd; bit [15:0] addr; bit [7:0] wdata; bit [3:0] tag; } mreq_t;
  typedef struct { bit [3:0] tag; bit [7:0] rdata; } mcpl_t;
  mreq_t mq[$];
  bit [3:0] mi[$];
  mcpl_t mc[$];
  bit merr = 1'b0;

  x_23k640_req_queue #(.DEPTH(DEPTH), .TAG_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_rd_n_wr(req_rd),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_tag(req_tag),
    .o_cpl_valid(o_cpl_valid), .i_cpl_ready(cpl_ready), .o_cpl_tag(o_cpl_tag),
    .o_cpl_rdata(o_cpl_rdata), .o_valid(o_valid), .i_accept(accept),
    .o_rd_n_wr(o_rd_n_wr), .o_addr(o_addr), .o_wdata(o_wdata),
    .i_ready(ready), .i_rdata(rdata), .o_idle(o_idle), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete(); mi.delete(); mc.delete(); merr = 1'b0;
  endtask

  // Reference model: apply one clock edge of the queue rules to the model queues.
  task automatic model_edge();
    int rs, is, cs;
    bit cpop;
    bit [3:0] t;
    mreq_t h, n;
    if (rst) begin
      model_clear();
      return;
    end
    rs = mq.size(); is = mi.size(); cs = mc.size();
    cpop = cpl_ready && (cs > 0);
    if (cpop) void'(mc.pop_front());
    if (accept && rs == 0) merr = 1'b1;
    if (ready && is == 0) merr = 1'b1;
    if (ready && is > 0) begin
      t = mi.pop_front();
      if (cs < DEPTH || cpop) mc.push_back('{t, rdata});
    end
    if (accept && rs > 0) begin
      h = mq.pop_front();
      if (h.rd) begin
        if (is == 2) merr = 1'b1;
        else mi.push_back(h.tag);
      end
    end
    if (req_valid && rs < DEPTH) begin
      n.rd = req_rd; n.addr = req_addr; n.wdata = req_wdata; n.tag = req_tag;
      mq.push_back(n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic push(input bit rd, input logic [15:0] a, input logic [7:0] d, input logic [3:0] t);
    req_valid = 1'b1; req_rd = rd; req_addr = a; req_wdata = d; req_tag = t;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_chk++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%0h exp=1", o_req_ready); end
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0h exp=0", o_valid); end
    n_chk++; if (o_cpl_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cpl_valid got=%0h exp=0", o_cpl_valid); end
    n_chk++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got=%0h exp=1", o_idle); end
    n_chk++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0h exp=0", o_err); end
  endtask

  task automatic test_writes();
    logic [15:0] ea;
    logic [7:0] ed;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_before%0d got=%0h exp=1", i, o_req_ready); end
      push(1'b0, 16'(16'h0010 + i), 8'(8'hA0 + i), 4'h0);
    end
    n_chk++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL wr_full_ready got=%0h exp=0", o_req_ready); end
    for (int i = 0; i < 4; i++) begin
      ea = 16'(16'h0010 + i); ed = 8'(8'hA0 + i);
      n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid%0d got=%0h exp=1", i, o_valid); end
      n_chk++; if (o_rd_n_wr !== 1'b0) begin n_fail++; $display("FAIL wr_rdnwr%0d got=%0h exp=0", i, o_rd_n_wr); end
      n_chk++; if (o_addr !== ea) begin n_fail++; $display("FAIL wr_addr%0d got=%0h exp=%0h", i, o_addr, ea); end
      n_chk++; if (o_wdata !== ed) begin n_fail++; $display("FAIL wr_wdata%0d got=%0h exp=%0h", i, o_wdata, ed); end
      accept = 1'b1; tick(); accept = 1'b0;
    end
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL wr_end_valid got=%0h exp=0", o_valid); end
    n_chk++; if (o_cpl_valid !== 1'b0) begin n_fail++; $display("FAIL wr_end_cpl got=%0h exp=0", o_cpl_valid); end
    n_chk++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL wr_end_idle got=%0h exp=1", o_idle); end
  endtask

  task automatic test_credit();
    logic [15:0] ea;
    for (int i = 0; i < 4; i++) push(1'b1, 16'(16'h0200 + i), 8'h00, 4'(i + 1));
    n_chk++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL cr_full_ready got=%0h exp=0", o_req_ready); end
    req_valid = 1'b1; req_rd = 1'b1; req_addr = 16'h0204; req_wdata = 8'h00; req_tag = 4'd5;
    for (int k = 0; k < 4; k++) begin
      ea = 16'(16'h0200 + k);
      n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL cr_valid%0d got=%0h exp=1", k, o_valid); end
      n_chk++; if (o_addr !== ea) begin n_fail++; $display("FAIL cr_addr%0d got=%0h exp=%0h", k, o_addr, ea); end
      accept = 1'b1; tick(); accept = 1'b0;
      ready = 1'b1; rdata = 8'(8'h11 + k); tick(); ready = 1'b0;
      req_valid = 1'b0;
    end
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL cr_blocked_valid got=%0h exp=0", o_valid); end
    n_chk++; if (o_addr !== 16'h0204) begin n_fail++; $display("FAIL cr_head5_addr got=%0h exp=204", o_addr); end
    n_chk++; if (o_cpl_valid !== 1'b1) begin n_fail++; $display("FAIL cr_cpl_valid got=%0h exp=1", o_cpl_valid); end
    n_chk++; if (o_cpl_tag !== 4'd1) begin n_fail++; $display("FAIL cr_cpl_tag got=%0h exp=1", o_cpl_tag); end
    n_chk++; if (o_cpl_rdata !== 8'h11) begin n_fail++; $display("FAIL cr_cpl_rdata got=%0h exp=11", o_cpl_rdata); end
    cpl_ready = 1'b1; tick(); cpl_ready = 1'b0;
    n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL cr_credit_back_valid got=%0h exp=1", o_valid); end
    n_chk++; if (o_cpl_tag !== 4'd2) begin n_fail++; $display("FAIL cr_cpl_tag2 got=%0h exp=2", o_cpl_tag); end
  endtask

  task automatic test_cpl_simul();
    logic [3:0] et [3];
    logic [7:0] ed [3];
    et[0] = 4'd3; et[1] = 4'd4; et[2] = 4'd5;
    ed[0] = 8'h13; ed[1] = 8'h14; ed[2] = 8'h55;
    accept = 1'b1; tick(); accept = 1'b0;
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL cs_empty_valid got=%0h exp=0", o_valid); end
    n_chk++; if (o_idle !== 1'b0) begin n_fail++; $display("FAIL cs_busy_idle got=%0h exp=0", o_idle); end
    ready = 1'b1; rdata = 8'h55; cpl_ready = 1'b1; tick(); ready = 1'b0; cpl_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (o_cpl_valid !== 1'b1) begin n_fail++; $display("FAIL cs_valid%0d got=%0h exp=1", i, o_cpl_valid); end
      n_chk++; if (o_cpl_tag !== et[i]) begin n_fail++; $display("FAIL cs_tag%0d got=%0h exp=%0h", i, o_cpl_tag, et[i]); end
      n_chk++; if (o_cpl_rdata !== ed[i]) begin n_fail++; $display("FAIL cs_rdata%0d got=%0h exp=%0h", i, o_cpl_rdata, ed[i]); end
      cpl_ready = 1'b1; tick(); cpl_ready = 1'b0;
    end
    n_chk++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL cs_end_idle got=%0h exp=1", o_idle); end
  endtask

  task automatic test_mixed();
    push(1'b1, 16'h0100, 8'h00, 4'd7);
    push(1'b0, 16'h0101, 8'h5A, 4'd0);
    push(1'b1, 16'h0102, 8'h00, 4'd9);
    n_chk++; if (o_rd_n_wr !== 1'b1 || o_addr !== 16'h0100) begin n_fail++; $display("FAIL mx_head0 got=%0h/%0h exp=1/100", o_rd_n_wr, o_addr); end
    accept = 1'b1; tick(); accept = 1'b0;
    ready = 1'b1; rdata = 8'hC1; tick(); ready = 1'b0;
    n_chk++; if (o_rd_n_wr !== 1'b0 || o_addr !== 16'h0101 || o_wdata !== 8'h5A) begin n_fail++; $display("FAIL mx_head1 got=%0h/%0h/%0h exp=0/101/5a", o_rd_n_wr, o_addr, o_wdata); end
    accept = 1'b1; tick(); accept = 1'b0;
    n_chk++; if (o_rd_n_wr !== 1'b1 || o_addr !== 16'h0102) begin n_fail++; $display("FAIL mx_head2 got=%0h/%0h exp=1/102", o_rd_n_wr, o_addr); end
    accept = 1'b1; tick(); accept = 1'b0;
    ready = 1'b1; rdata = 8'hC2; tick(); ready = 1'b0;
    n_chk++; if (o_cpl_tag !== 4'd7 || o_cpl_rdata !== 8'hC1) begin n_fail++; $display("FAIL mx_cpl0 got=%0h/%0h exp=7/c1", o_cpl_tag, o_cpl_rdata); end
    cpl_ready = 1'b1; tick(); cpl_ready = 1'b0;
    n_chk++; if (o_cpl_tag !== 4'd9 || o_cpl_rdata !== 8'hC2) begin n_fail++; $display("FAIL mx_cpl1 got=%0h/%0h exp=9/c2", o_cpl_tag, o_cpl_rdata); end
    cpl_ready = 1'b1; tick(); cpl_ready = 1'b0;
    n_chk++; if (o_cpl_valid !== 1'b0) begin n_fail++; $display("FAIL mx_no_write_cpl got=%0h exp=0", o_cpl_valid); end
    n_chk++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL mx_err got=%0h exp=0", o_err); end
  endtask

  task automatic test_err();
    accept = 1'b1; tick(); accept = 1'b0;
    n_chk++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL er_set got=%0h exp=1", o_err); end
    n_chk++; if (o_valid !== 1'b0 || o_req_ready !== 1'b1 || o_idle !== 1'b1) begin n_fail++; $display("FAIL er_flags got=%0h/%0h/%0h exp=0/1/1", o_valid, o_req_ready, o_idle); end
    push(1'b0, 16'h0ABC, 8'h3C, 4'd0);
    n_chk++; if (o_valid !== 1'b1 || o_addr !== 16'h0ABC) begin n_fail++; $display("FAIL er_ptr got=%0h/%0h exp=1/abc", o_valid, o_addr); end
    accept = 1'b1; tick(); accept = 1'b0;
    tick();
    n_chk++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL er_sticky got=%0h exp=1", o_err); end
    n_chk++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL er_idle got=%0h exp=1", o_idle); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 3; i++) push(1'b1, 16'(16'h0300 + i), 8'h00, 4'(i + 10));
    accept = 1'b1; tick(); accept = 1'b0;
    n_chk++; if (o_idle !== 1'b0 || o_valid !== 1'b1) begin n_fail++; $display("FAIL rm_before got=%0h/%0h exp=0/1", o_idle, o_valid); end
    #2 rst = 1'b1;
    model_clear();
    #1;
    n_chk++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_req_ready got=%0h exp=1", o_req_ready); end
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got=%0h exp=0", o_valid); end
    n_chk++; if (o_cpl_valid !== 1'b0) begin n_fail++; $display("FAIL rm_cpl_valid got=%0h exp=0", o_cpl_valid); end
    n_chk++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL rm_idle got=%0h exp=1", o_idle); end
    n_chk++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rm_err got=%0h exp=0", o_err); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit ev;
    for (int c = 0; c < 1500; c++) begin
      ev = (mq.size() > 0) && (!mq[0].rd || (mc.size() + mi.size() < DEPTH));
      n_chk++; if (o_req_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_req_ready c=%0d got=%0h exp=%0h", c, o_req_ready, mq.size() < DEPTH); end
      n_chk++; if (o_valid !== ev) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%0h exp=%0h", c, o_valid, ev); end
      if (mq.size() > 0) begin
        n_chk++;
        if (o_rd_n_wr !== mq[0].rd || o_addr !== mq[0].addr || (!mq[0].rd && o_wdata !== mq[0].wdata)) begin
          n_fail++; $display("FAIL rnd_head c=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, o_rd_n_wr, o_addr, o_wdata, mq[0].rd, mq[0].addr, mq[0].wdata);
        end
      end
      n_chk++; if (o_cpl_valid !== (mc.size() > 0)) begin n_fail++; $display("FAIL rnd_cpl_valid c=%0d got=%0h exp=%0h", c, o_cpl_valid, mc.size() > 0); end
      if (mc.size() > 0) begin
        n_chk++;
        if (o_cpl_tag !== mc[0].tag || o_cpl_rdata !== mc[0].rdata) begin
          n_fail++; $display("FAIL rnd_cpl c=%0d got=%0h/%0h exp=%0h/%0h", c, o_cpl_tag, o_cpl_rdata, mc[0].tag, mc[0].rdata);
        end
      end
      n_chk++; if (o_idle !== (mq.size() == 0 && mi.size() == 0 && mc.size() == 0)) begin n_fail++; $display("FAIL rnd_idle c=%0d got=%0h", c, o_idle); end
      n_chk++; if (o_err !== merr) begin n_fail++; $display("FAIL rnd_err c=%0d got=%0h exp=%0h", c, o_err, merr); end
      req_valid = ($urandom_range(0, 1) == 1);
      req_rd = ($urandom_range(0, 1) == 1);
      req_addr = 16'($urandom);
      req_wdata = 8'($urandom);
      req_tag = 4'($urandom);
      cpl_ready = ($urandom_range(0, 2) == 0);
      accept = ev && (!mq[0].rd || mi.size() < 2) && ($urandom_range(0, 2) != 0);
      ready = (mi.size() > 0) && ($urandom_range(0, 2) == 0);
      rdata = 8'($urandom);
      tick();
    end
    req_valid = 1'b0; cpl_ready = 1'b0; accept = 1'b0; ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_writes();
    test_credit();
    test_cpl_simul();
    test_mixed();
    test_err();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
